shift_serializer: RTL and testbench
===================================

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each word popped from the upstream prefetch FIFO; legal range 1..32.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per serial bit; even values only, legal range 2..256.
REQ-003 Parameter MSB_FIRST, default 1: 1 shifts bit DATA_WIDTH-1 first; 0 shifts bit 0 first.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset; asynchronous, active-high.
REQ-006 Port enable, input, 1: permits the block to start new words.
REQ-007 Port fifo_rd_vld, input, 1: upstream prefetch FIFO holds a valid word on fifo_rd_data.
REQ-008 Port fifo_rd_data, input, DATA_WIDTH: head word of the upstream FIFO, valid while fifo_rd_vld=1.
REQ-009 Port fifo_rd_en, output, 1: pop strobe to the upstream FIFO.
REQ-010 Port ser_clk, output, 1: serial bit clock.
REQ-011 Port ser_dat, output, 1: serial data.
REQ-012 Port ser_frame, output, 1: high while any word is being shifted.
REQ-013 Port busy, output, 1: high whenever the state is not IDLE.
REQ-014 Port tx_count, output, 16: count of fully shifted words.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SHIFT, plus a shift register (DATA_WIDTH bits), a bit counter, and a divider counter div_cnt (0..CLK_DIV-1).
REQ-016 The block SHALL treat fifo_rd_data as a prefetch (show-ahead) word: a transfer occurs on a cycle where fifo_rd_en=1 and fifo_rd_vld=1, and the word is captured at that same rising edge.
REQ-017 fifo_rd_en SHALL be combinational and SHALL equal 1 only when fifo_rd_vld=1, enable=1, and either the state is IDLE, or the state is SHIFT with the last bit on div_cnt=CLK_DIV-1.
REQ-018 fifo_rd_en SHALL never be 1 while fifo_rd_vld=0.
REQ-019 On a transfer, the FSM SHALL enter SHIFT at the next edge with div_cnt=0 and bit index 0; ser_dat SHALL then present the first bit selected by MSB_FIRST.
REQ-020 In SHIFT, div_cnt SHALL increment every cycle and wrap from CLK_DIV-1 to 0.
REQ-021 ser_clk SHALL be 0 for div_cnt < CLK_DIV/2 and 1 otherwise, so the receiver samples on the rising ser_clk edge mid-bit.
REQ-022 At div_cnt=CLK_DIV-1, the block SHALL advance to the next bit; ser_dat SHALL change only at that boundary.
REQ-023 Each word SHALL occupy exactly DATA_WIDTH*CLK_DIV clk cycles in SHIFT.
REQ-024 At the last bit with div_cnt=CLK_DIV-1:
- If a transfer occurs (REQ-017), the block SHALL load the next word with zero gap, ser_frame staying 1.
- Otherwise, the FSM SHALL return to IDLE.
REQ-025 tx_count SHALL increment by 1 at the end of every completed word and wrap from 0xFFFF to 0x0000.
REQ-026 Deasserting enable during SHIFT SHALL NOT abort the current word; the word finishes and the FSM then goes to IDLE.
REQ-027 fifo_rd_vld dropping during SHIFT SHALL have no effect until the next load decision.
REQ-028 In IDLE, outputs SHALL be: ser_clk=0, ser_dat=0, ser_frame=0, busy=0.
REQ-029 In SHIFT, ser_frame and busy SHALL be 1.

Reset
REQ-030 While rst=1, the block SHALL, immediately and independent of clk, force:
- state=IDLE, div_cnt=0, bit counter=0, shift register=0, tx_count=0
- ser_clk=0, ser_dat=0, ser_frame=0, busy=0
- fifo_rd_en=0 (gated by rst).
REQ-031 Reset asserted mid-word SHALL discard the partial word without incrementing tx_count; after release, operation SHALL restart from IDLE.

Verification (DATA_WIDTH=8, CLK_DIV=4, MSB_FIRST=1 unless stated)
REQ-032 Single word: rd_vld=1 with 0xA5 for one pop, enable=1 -> one fifo_rd_en pulse; ser_dat=1,0,1,0,0,1,0,1, 4 cycles each; ser_frame high 32 cycles; tx_count=1.
REQ-033 Back-to-back: FIFO holds 0x3C,0xFF -> exactly two rd_en pulses 32 cycles apart; ser_frame high 64 continuous cycles; tx_count=2.
REQ-034 LSB-first: MSB_FIRST=0, word 0x01 -> ser_dat=1 for the first 4 cycles, then 0 for 28 cycles.
REQ-035 Enable drop: enable falls 10 cycles into word 0x81 with FIFO non-empty -> word completes (32 cycles), no further rd_en, block returns to IDLE.
REQ-036 Reset mid-word: rst pulse at cycle 12 of word 0xF0 -> all outputs 0 at once, tx_count stays 0; the next word after release starts cleanly.
REQ-037 Wrap: preload tx_count=0xFFFF via 65535 words (or force) and send one more word -> tx_count=0x0000.

Source files
------------

// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter fed from a show-ahead FIFO. Each word is shifted
// out over DATA_WIDTH*CLK_DIV clocks, and a gapless reload happens on the last bit.
module shift_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  ser_clk,
  output logic                  ser_dat,
  output logic                  ser_frame,
  output logic                  busy,
  output logic [15:0]           tx_count
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                r_state;
  logic [DivW-1:0]       r_div_cnt;
  logic [BitW-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [15:0]           r_tx_count;

  state_e                w_state_nxt;
  logic [DivW-1:0]       w_div_nxt;
  logic [BitW-1:0]       w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [15:0]           w_tx_nxt;

  logic w_in_shift;
  logic w_div_end;
  logic w_last_tick;

  assign w_in_shift  = (r_state == StShift);
  assign w_div_end   = (r_div_cnt == DivLast);
  assign w_last_tick = w_in_shift && w_div_end && (r_bit_cnt == BitLast);

  // Pop only when a load decision is being made this cycle; rst gates it so
  // the FIFO never loses a word while the block is held in reset.
  assign fifo_rd_en = !rst && fifo_rd_vld && enable && (!w_in_shift || w_last_tick);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = r_tx_count;
    unique case (r_state)
      StIdle: begin
        if (fifo_rd_en) begin
          w_state_nxt = StShift;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_shreg_nxt = fifo_rd_data;
        end
      end
      StShift: begin
        w_div_nxt = w_div_end ? '0 : r_div_cnt + DivW'(1);
        if (w_last_tick) begin
          w_tx_nxt = r_tx_count + 16'd1;
          if (fifo_rd_en) begin
            w_bit_nxt   = '0;
            w_shreg_nxt = fifo_rd_data;
          end else begin
            w_state_nxt = StIdle;
          end
        end else if (w_div_end) begin
          w_bit_nxt   = r_bit_cnt + BitW'(1);
          w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_cnt  <= w_div_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shreg    <= w_shreg_nxt;
      r_tx_count <= w_tx_nxt;
    end
  end

  // Outputs are gated by state so IDLE always presents a quiet line.
  assign ser_clk   = w_in_shift && (r_div_cnt >= DivHalf);
  assign ser_dat   = w_in_shift && (MSB_FIRST ? r_shreg[DATA_WIDTH-1] : r_shreg[0]);
  assign ser_frame = w_in_shift;
  assign busy      = w_in_shift;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: MSB-first default instance plus an
// LSB-first instance sharing the same stimulus.
module tb_shift_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_rd_vld = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en, ser_clk, ser_dat, ser_frame, busy;
  logic [15:0] tx_count;
  logic       l_rd_en, l_ser_clk, l_ser_dat, l_ser_frame, l_busy;
  logic [15:0] l_tx_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_serializer #(.DATA_WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .ser_clk(ser_clk),
    .ser_dat(ser_dat), .ser_frame(ser_frame), .busy(busy), .tx_count(tx_count)
  );

  shift_serializer #(.DATA_WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(l_rd_en), .ser_clk(l_ser_clk),
    .ser_dat(l_ser_dat), .ser_frame(l_ser_frame), .busy(l_busy), .tx_count(l_tx_count)
  );

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    fifo_rd_vld = 1'b0;
    fifo_rd_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    fifo_rd_vld = 1'b1;
    fifo_rd_data = 8'hFF;
    #3;
    checks++;
    if ({fifo_rd_en, ser_clk, ser_dat, ser_frame, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 00000",
               {fifo_rd_en, ser_clk, ser_dat, ser_frame, busy});
    end
    @(negedge clk);
    checks++;
    if (tx_count !== 16'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: tx_count=%h busy=%b want 0000/0", tx_count, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] w;
    int pulses;
    w = 8'hA5;
    pulses = 0;
    do_reset();
    enable = 1'b1;
    fifo_rd_data = w;
    fifo_rd_vld = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: rd_en=%b want 1", fifo_rd_en);
    end
    @(posedge clk);
    #1 fifo_rd_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
      checks++;
      if (ser_frame !== 1'b1 || busy !== 1'b1 || ser_dat !== w[7 - i/4] ||
          ser_clk !== ((i % 4) >= 2)) begin
        failures++;
        $display("FAIL single_shift[%0d]: frame=%b busy=%b dat=%b clk=%b want 1 1 %b %b",
                 i, ser_frame, busy, ser_dat, ser_clk, w[7 - i/4], ((i % 4) >= 2));
      end
    end
    @(negedge clk);
    checks++;
    if (ser_frame !== 1'b0 || busy !== 1'b0 || ser_dat !== 1'b0 || ser_clk !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: frame=%b busy=%b dat=%b clk=%b want 0 0 0 0",
               ser_frame, busy, ser_dat, ser_clk);
    end
    checks++;
    if (tx_count !== 16'd1 || pulses != 0) begin
      failures++;
      $display("FAIL single_count: tx_count=%0d extra_pops=%0d want 1/0", tx_count, pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    int pulses, pos;
    w0 = 8'h3C;
    w1 = 8'hFF;
    pulses = 0;
    pos = -1;
    do_reset();
    enable = 1'b1;
    fifo_rd_data = w0;
    fifo_rd_vld = 1'b1;
    @(posedge clk);
    #1 fifo_rd_data = w1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        pulses++;
        pos = i;
      end
      checks++;
      if (ser_frame !== 1'b1 ||
          ser_dat !== ((i < 32) ? w0[7 - (i % 32)/4] : w1[7 - (i % 32)/4])) begin
        failures++;
        $display("FAIL b2b_shift[%0d]: frame=%b dat=%b", i, ser_frame, ser_dat);
      end
      @(posedge clk);
      #1;
      if (i == 31) fifo_rd_vld = 1'b0;
    end
    checks++;
    if (pulses != 1 || pos != 31) begin
      failures++;
      $display("FAIL b2b_pops: pops=%0d at=%0d want 1 at 31", pulses, pos);
    end
    @(negedge clk);
    checks++;
    if (ser_frame !== 1'b0 || tx_count !== 16'd2) begin
      failures++;
      $display("FAIL b2b_end: frame=%b tx_count=%0d want 0/2", ser_frame, tx_count);
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    enable = 1'b1;
    fifo_rd_data = 8'h01;
    fifo_rd_vld = 1'b1;
    @(posedge clk);
    #1 fifo_rd_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (l_ser_dat !== (i < 4) || ser_dat !== (i >= 28)) begin
        failures++;
        $display("FAIL lsb_shift[%0d]: lsb_dat=%b msb_dat=%b want %b %b",
                 i, l_ser_dat, ser_dat, (i < 4), (i >= 28));
      end
    end
    @(negedge clk);
    checks++;
    if (l_ser_frame !== 1'b0 || l_tx_count !== 16'd1) begin
      failures++;
      $display("FAIL lsb_end: frame=%b tx_count=%0d want 0/1", l_ser_frame, l_tx_count);
    end
  endtask

  task automatic test_enable_drop();
    int pulses;
    pulses = 0;
    do_reset();
    enable = 1'b1;
    fifo_rd_data = 8'h81;
    fifo_rd_vld = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 10) enable = 1'b0;
      #1;
      if (fifo_rd_en) pulses++;
      checks++;
      if (ser_frame !== 1'b1 || ser_dat !== ((i < 4) || (i >= 28))) begin
        failures++;
        $display("FAIL endrop_shift[%0d]: frame=%b dat=%b", i, ser_frame, ser_dat);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0 || tx_count !== 16'd1) begin
      failures++;
      $display("FAIL endrop_end: pops=%0d busy=%b tx_count=%0d want 0/0/1",
               pulses, busy, tx_count);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'h5A;
    do_reset();
    enable = 1'b1;
    fifo_rd_data = 8'hF0;
    fifo_rd_vld = 1'b1;
    @(posedge clk);
    #1 fifo_rd_vld = 1'b0;
    repeat (13) @(negedge clk);
    #2;
    fifo_rd_vld = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, ser_clk, ser_dat, ser_frame, busy} !== 5'b0 || tx_count !== 16'd0) begin
      failures++;
      $display("FAIL midrst_outputs: outs=%b tx_count=%0d want 00000/0",
               {fifo_rd_en, ser_clk, ser_dat, ser_frame, busy}, tx_count);
    end
    @(negedge clk);
    rst = 1'b0;
    fifo_rd_data = w;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart_pop: rd_en=%b want 1", fifo_rd_en);
    end
    @(posedge clk);
    #1 fifo_rd_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (ser_frame !== 1'b1 || ser_dat !== w[7 - i/4]) begin
        failures++;
        $display("FAIL midrst_shift[%0d]: frame=%b dat=%b want 1 %b",
                 i, ser_frame, ser_dat, w[7 - i/4]);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_count !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_count: tx_count=%0d busy=%b want 1/0", tx_count, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force u_dut.r_tx_count = 16'hFFFF;
    @(negedge clk);
    release u_dut.r_tx_count;
    @(negedge clk);
    enable = 1'b1;
    fifo_rd_data = 8'h42;
    fifo_rd_vld = 1'b1;
    @(posedge clk);
    #1 fifo_rd_vld = 1'b0;
    repeat (33) @(negedge clk);
    checks++;
    if (tx_count !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_count: tx_count=%h busy=%b want 0000/0", tx_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_enable_drop();
    test_reset_mid_word();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
